pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_pkg.sv | 25 ++
 rtl/pipeline_hazard_controller_load_use_detect.sv | 18 +
 rtl/pipeline_hazard_controller.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, control strobe bundle, NOP encoding.
package pipeline_hazard_controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    REDIRECT   = 2'd3
  } hazard_state_e;

  // addi x0, x0, 0 -- the bubble a flushed IF/ID register presents downstream
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
  } hazard_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Load-use detector: a load in EX whose destination feeds a source of the instruction in ID.
module hazard_load_use_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  load_use_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: stall/flush/redirect sequencing for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mispredict_i,
  input  logic                  imem_ready_i,
  input  logic                  dmem_busy_i,
  output logic                  pc_write_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_stall_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_stall_o,
  output logic [STATE_W-1:0]    state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

  hazard_state_e state_q, state_d;
  logic          pending_q, pending_d;
  logic          load_use, mispredict;
  hazard_ctrl_t  ctrl;

  hazard_load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .ex_rd_i       (ex_rd_i),
    .ex_mem_read_i (ex_mem_read_i),
    .load_use_o    (load_use)
  );

  // A mispredict seen during a memory freeze is remembered and replayed once the freeze lifts
  assign mispredict = ex_mispredict_i || pending_q;

  always_comb begin
    ctrl      = '0;
    state_d   = RUN;
    pending_d = pending_q;
    if (!reset_n) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (dmem_busy_i) begin
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      state_d           = MEM_WAIT;
      pending_d         = pending_q || ex_mispredict_i;
    end else if (mispredict) begin
      ctrl.pc_write    = 1'b1;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      state_d          = REDIRECT;
      pending_d        = 1'b0;
    end else if (state_q == REDIRECT) begin
      // ID holds only squashed fetches here, so load-use cannot apply
      ctrl.if_id_flush = 1'b1;
      ctrl.pc_write    = imem_ready_i;
      state_d          = imem_ready_i ? RUN : REDIRECT;
    end else if (load_use && (state_q != LOAD_STALL)) begin
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      state_d          = LOAD_STALL;
    end else if (!imem_ready_i) begin
      ctrl.if_id_flush = 1'b1;
    end else begin
      ctrl.pc_write = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign pc_write_o     = ctrl.pc_write;
  assign if_id_stall_o  = ctrl.if_id_stall;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_stall_o  = ctrl.id_ex_stall;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_stall_o = ctrl.ex_mem_stall;
  assign state_o        = reset_n ? state_q : RUN;

  if (CNT_W < 1) begin : g_cnt_w_invalid
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_ONE;
      if (ctrl.id_ex_flush && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus randomized traffic vs a flag-based model.
module tb_pipeline_hazard_controller;

  localparam int AW      = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          ex_mem_read, ex_mispredict, imem_ready, dmem_busy;
  logic          pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic [1:0]    state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1_i        (id_rs1),
    .id_rs2_i        (id_rs2),
    .ex_rd_i         (ex_rd),
    .ex_mem_read_i   (ex_mem_read),
    .ex_mispredict_i (ex_mispredict),
    .imem_ready_i    (imem_ready),
    .dmem_busy_i     (dmem_busy),
    .pc_write_o      (pc_write),
    .if_id_stall_o   (if_id_stall),
    .if_id_flush_o   (if_id_flush),
    .id_ex_stall_o   (id_ex_stall),
    .id_ex_flush_o   (id_ex_flush),
    .ex_mem_stall_o  (ex_mem_stall),
    .state_o         (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: what the pipeline is currently doing, as independent facts
  bit m_redirecting, m_load_stalled, m_mem_waiting, m_pending;
  int m_stall_cnt, m_flush_cnt;

  task automatic idle_inputs();
    reset_n = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_mispredict = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
  endtask

  // Called at a negedge with inputs applied; checks this cycle, advances the model, returns at next negedge
  task automatic step();
    bit pc, fi, fe, si, se, sm, hit, mis;
    int st;
    #1;
    hit = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    mis = ex_mispredict || m_pending;
    {pc, fi, fe, si, se, sm} = '0;
    st = 0;
    if (!reset_n) begin
      fi = 1; fe = 1;
    end else begin
      if (m_mem_waiting) st = 2;
      else if (m_redirecting) st = 3;
      else if (m_load_stalled) st = 1;
      if (dmem_busy) begin
        si = 1; se = 1; sm = 1;
      end else if (mis) begin
        pc = 1; fi = 1; fe = 1;
      end else if (m_redirecting) begin
        fi = 1; pc = imem_ready;
      end else if (hit && !m_load_stalled) begin
        si = 1; fe = 1;
      end else if (!imem_ready) begin
        fi = 1;
      end else begin
        pc = 1;
      end
    end
    check_eq("pc_write", 32'(pc_write), 32'(pc));
    check_eq("if_id_stall", 32'(if_id_stall), 32'(si));
    check_eq("if_id_flush", 32'(if_id_flush), 32'(fi));
    check_eq("id_ex_stall", 32'(id_ex_stall), 32'(se));
    check_eq("id_ex_flush", 32'(id_ex_flush), 32'(fe));
    check_eq("ex_mem_stall", 32'(ex_mem_stall), 32'(sm));
    check_eq("state", 32'(state), 32'(st));
    check_eq("if_id_stall_and_flush", 32'(if_id_stall & if_id_flush), 32'd0);
    check_eq("id_ex_stall_and_flush", 32'(id_ex_stall & id_ex_flush), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
`endif
    @(posedge clk);
    if (!reset_n) begin
      {m_redirecting, m_load_stalled, m_mem_waiting, m_pending} = '0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (!pc && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (fe && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      if (dmem_busy) begin
        m_mem_waiting = 1; m_redirecting = 0; m_load_stalled = 0;
        m_pending = m_pending || ex_mispredict;
      end else if (mis) begin
        m_redirecting = 1; m_mem_waiting = 0; m_load_stalled = 0; m_pending = 0;
      end else if (m_redirecting) begin
        m_redirecting = !imem_ready;
      end else begin
        m_mem_waiting = 0;
        m_load_stalled = hit && !m_load_stalled;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);

    // Reset values, with unrelated inputs active
    ex_mispredict = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    check_eq("rst_pc_write", 32'(pc_write), 32'd0);
    check_eq("rst_if_id_flush", 32'(if_id_flush), 32'd1);
    check_eq("rst_id_ex_flush", 32'(id_ex_flush), 32'd1);
    check_eq("rst_state", 32'(state), 32'd0);
    step();
    step();
    idle_inputs();
    step();

    // Load-use on rs1: one stall cycle, then RUN with the same load still in EX
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd0;
    #1;
    check_eq("lu_pc_write", 32'(pc_write), 32'd0);
    check_eq("lu_if_id_stall", 32'(if_id_stall), 32'd1);
    check_eq("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    step();
    check_eq("lu_state_stall", 32'(state), 32'd1);
    check_eq("lu_no_back_to_back", 32'(pc_write), 32'd1);
    step();
    idle_inputs();
    check_eq("lu_back_to_run", 32'(state), 32'd0);
    step();

    // Load into x0 is not a dependency
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    check_eq("lu_x0_pc_write", 32'(pc_write), 32'd1);
    check_eq("lu_x0_stall", 32'(if_id_stall), 32'd0);
    step();
    idle_inputs();

    // Mispredict then fetch not ready for two cycles
    ex_mispredict = 1'b1;
    #1;
    check_eq("mp_flush_if", 32'(if_id_flush), 32'd1);
    check_eq("mp_flush_id", 32'(id_ex_flush), 32'd1);
    check_eq("mp_pc_write", 32'(pc_write), 32'd1);
    step();
    ex_mispredict = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("redir_state", 32'(state), 32'd3);
      check_eq("redir_flush", 32'(if_id_flush), 32'd1);
      check_eq("redir_pc_hold", 32'(pc_write), 32'd0);
      step();
    end
    imem_ready = 1'b1;
    #1;
    check_eq("redir_ready_pc", 32'(pc_write), 32'd1);
    step();
    check_eq("redir_exit_state", 32'(state), 32'd0);
    step();

    // Memory freeze for three cycles with a mispredict buried in cycle 1
    for (int i = 0; i < 3; i++) begin
      dmem_busy = 1'b1;
      ex_mispredict = (i == 1);
      #1;
      check_eq("freeze_pc", 32'(pc_write), 32'd0);
      check_eq("freeze_ex_mem_stall", 32'(ex_mem_stall), 32'd1);
      check_eq("freeze_flush", 32'(if_id_flush | id_ex_flush), 32'd0);
      step();
    end
    dmem_busy = 1'b0; ex_mispredict = 1'b0;
    #1;
    check_eq("freeze_exit_state", 32'(state), 32'd2);
    check_eq("pending_redirect_flush", 32'(id_ex_flush & if_id_flush & pc_write), 32'd1);
    step();
    check_eq("pending_redirect_state", 32'(state), 32'd3);
    step();
    step();

    // Reset in the middle of a freeze drops the pending mispredict
    dmem_busy = 1'b1; ex_mispredict = 1'b1;
    step();
    step();
    check_eq("mw_before_reset", 32'(state), 32'd2);
    do_reset();
    idle_inputs();
    #1;
    check_eq("mw_reset_state", 32'(state), 32'd0);
    check_eq("mw_reset_pending_clear", 32'(pc_write & ~if_id_flush), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("mw_reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("mw_reset_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    step();

`ifdef HAZARD_PERF_CNT_EN
    // Counter saturation
    dmem_busy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_eq("stall_cnt_saturated", 32'(stall_cnt), 32'd15);
    idle_inputs();
    step();
`endif

    // Randomized traffic, small register range so dependencies are common
    for (int i = 0; i < 1500; i++) begin
      reset_n       = ($urandom_range(0, 49) != 0);
      id_rs1        = AW'($urandom_range(0, 3));
      id_rs2        = AW'($urandom_range(0, 3));
      ex_rd         = AW'($urandom_range(0, 3));
      ex_mem_read   = 1'($urandom_range(0, 1));
      ex_mispredict = ($urandom_range(0, 9) == 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      dmem_busy     = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
